// File: rtl/gray_ptr_ctrl.sv
// Pointer controller for a power-of-two circular buffer. It keeps binary
// read/write pointers with a wrap bit and exports registered Gray copies.
// Full and empty are compared in the Gray domain.
module gray_ptr_ctrl #(
    parameter  int unsigned Depth     = 8,
    localparam int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic                 push_i,
    output logic                 push_ready_o,
    input  logic                 pop_i,
    output logic                 pop_valid_o,
    output logic [AddrWidth-1:0] wr_addr_o,
    output logic [AddrWidth-1:0] rd_addr_o,
    output logic [AddrWidth:0]   wr_ptr_gray_o,
    output logic [AddrWidth:0]   rd_ptr_gray_o,
    output logic [AddrWidth:0]   count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned PtrWidth = AddrWidth + 1;
    typedef logic [PtrWidth-1:0] ptr_t;

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_depth_check
        $fatal(1, "gray_ptr_ctrl: Depth must be a power of two and >= 2");
    end

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    ptr_t wr_bin_q, wr_bin_d;
    ptr_t rd_bin_q, rd_bin_d;
    ptr_t wr_gray_q, wr_gray_d;
    ptr_t rd_gray_q, rd_gray_d;
    logic full, empty;
    logic push_fire, pop_fire;

    // Flags depend only on registered Gray pointers, never on push_i/pop_i.
    assign empty = (wr_gray_q == rd_gray_q);

    if (AddrWidth == 1) begin : g_full_depth2
        assign full = (wr_gray_q == ~rd_gray_q);
    end else begin : g_full
        assign full = (wr_gray_q == {~rd_gray_q[AddrWidth -: 2], rd_gray_q[AddrWidth-2:0]});
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        push_fire = push_i & ~full;
        pop_fire  = pop_i & ~empty;
        wr_bin_d  = wr_bin_q + ptr_t'(push_fire);
        rd_bin_d  = rd_bin_q + ptr_t'(pop_fire);
        wr_gray_d = bin2gray(wr_bin_d);
        rd_gray_d = bin2gray(rd_bin_d);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_bin_q  <= '0;
            rd_bin_q  <= '0;
            wr_gray_q <= '0;
            rd_gray_q <= '0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            rd_bin_q  <= rd_bin_d;
            wr_gray_q <= wr_gray_d;
            rd_gray_q <= rd_gray_d;
        end
    end

    assign full_o        = full;
    assign empty_o       = empty;
    assign push_ready_o  = ~full;
    assign pop_valid_o   = ~empty;
    assign wr_addr_o     = wr_bin_q[AddrWidth-1:0];
    assign rd_addr_o     = rd_bin_q[AddrWidth-1:0];
    assign wr_ptr_gray_o = wr_gray_q;
    assign rd_ptr_gray_o = rd_gray_q;
    assign count_o       = wr_bin_q - rd_bin_q;

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Bench for gray_ptr_ctrl (Depth=8). The reference model counts total pushes
// and pops as plain integers and derives every output from those two counts.
module tb_gray_ptr_ctrl;

    localparam int Depth = 8;
    localparam int AW    = 3;

    logic          clk_i = 1'b0;
    logic          arst_ni;
    logic          push_i, pop_i;
    logic          push_ready_o, pop_valid_o, full_o, empty_o;
    logic [AW-1:0] wr_addr_o, rd_addr_o;
    logic [AW:0]   wr_ptr_gray_o, rd_ptr_gray_o, count_o;

    int checks   = 0;
    int failures = 0;

    int         m_wr = 0;
    int         m_rd = 0;
    bit         cmp_en = 1'b0;
    logic [3:0] prev_wg = '0;
    logic [3:0] prev_rg = '0;

    gray_ptr_ctrl #(.Depth(Depth)) dut (
        .clk_i         (clk_i),
        .arst_ni       (arst_ni),
        .push_i        (push_i),
        .push_ready_o  (push_ready_o),
        .pop_i         (pop_i),
        .pop_valid_o   (pop_valid_o),
        .wr_addr_o     (wr_addr_o),
        .rd_addr_o     (rd_addr_o),
        .wr_ptr_gray_o (wr_ptr_gray_o),
        .rd_ptr_gray_o (rd_ptr_gray_o),
        .count_o       (count_o),
        .full_o        (full_o),
        .empty_o       (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_bin(input int n);
        return 4'(n % (2 * Depth));
    endfunction

    function automatic logic [3:0] m_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // Drive one cycle; the model decides acceptance from its own occupancy.
    task automatic cycle(input logic p, input logic q);
        bit pf, qf;
        push_i = p;
        pop_i  = q;
        pf = p && ((m_wr - m_rd) < Depth);
        qf = q && ((m_wr - m_rd) > 0);
        @(posedge clk_i);
        if (pf) m_wr++;
        if (qf) m_rd++;
        #1;
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        int occ;
        if (cmp_en) begin
            occ = m_wr - m_rd;
            check("count",      count_o,       occ);
            check("full",       full_o,        occ == Depth);
            check("empty",      empty_o,       occ == 0);
            check("push_ready", push_ready_o,  occ != Depth);
            check("pop_valid",  pop_valid_o,   occ != 0);
            check("wr_addr",    wr_addr_o,     m_wr % Depth);
            check("rd_addr",    rd_addr_o,     m_rd % Depth);
            check("wr_gray",    wr_ptr_gray_o, m_gray(m_bin(m_wr)));
            check("rd_gray",    rd_ptr_gray_o, m_gray(m_bin(m_rd)));
            check("wr_gray_hamming", 32'($countones(wr_ptr_gray_o ^ prev_wg) <= 1), 1);
            check("rd_gray_hamming", 32'($countones(rd_ptr_gray_o ^ prev_rg) <= 1), 1);
            prev_wg = wr_ptr_gray_o;
            prev_rg = rd_ptr_gray_o;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_empty"},      empty_o,       1);
        check({tag, "_full"},       full_o,        0);
        check({tag, "_count"},      count_o,       0);
        check({tag, "_ready"},      push_ready_o,  1);
        check({tag, "_valid"},      pop_valid_o,   0);
        check({tag, "_wr_addr"},    wr_addr_o,     0);
        check({tag, "_rd_addr"},    rd_addr_o,     0);
        check({tag, "_wr_gray"},    wr_ptr_gray_o, 4'b0000);
        check({tag, "_rd_gray"},    rd_ptr_gray_o, 4'b0000);
    endtask

    initial begin
        arst_ni = 1'b0;
        push_i  = 1'b0;
        pop_i   = 1'b0;

        // Reset held: toggling push_i must have no effect.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i);
            #1 push_i = ~push_i;
        end
        #1 check_reset_values("reset");
        push_i  = 1'b0;
        arst_ni = 1'b1;
        cmp_en  = 1'b1;

        // Fill: addresses 0..7, then full with Gray 1100.
        for (int i = 0; i < Depth; i++) begin
            check("fill_addr_seq", wr_addr_o, i);
            cycle(1'b1, 1'b0);
        end
        check("fill_count", count_o, 8);
        check("fill_full", full_o, 1);
        check("fill_wr_gray", wr_ptr_gray_o, 4'b1100);
        cycle(1'b1, 1'b0);
        check("push_when_full_count", count_o, 8);
        check("push_when_full_gray", wr_ptr_gray_o, 4'b1100);
        check("push_when_full_addr", wr_addr_o, 0);

        // Drain: addresses 0..7, then empty with Gray 1100.
        for (int i = 0; i < Depth; i++) begin
            check("drain_addr_seq", rd_addr_o, i);
            cycle(1'b0, 1'b1);
        end
        check("drain_empty", empty_o, 1);
        check("drain_rd_gray", rd_ptr_gray_o, 4'b1100);
        cycle(1'b0, 1'b1);
        check("pop_when_empty_count", count_o, 0);
        check("pop_when_empty_gray", rd_ptr_gray_o, 4'b1100);

        // Count 3, then 5 simultaneous cycles: wr 11->16(=0), rd 8->13.
        repeat (3) cycle(1'b1, 1'b0);
        repeat (5) cycle(1'b1, 1'b1);
        check("simul_count", count_o, 3);
        check("simul_wr_addr", wr_addr_o, 0);
        check("simul_rd_addr", rd_addr_o, 5);
        check("simul_wr_gray", wr_ptr_gray_o, 4'b0000);
        check("simul_rd_gray", rd_ptr_gray_o, 4'b1011);

        // Full with both requests: pop only.
        repeat (5) cycle(1'b1, 1'b0);
        check("full_again", full_o, 1);
        cycle(1'b1, 1'b1);
        check("full_both_count", count_o, 7);
        check("full_both_full", full_o, 0);

        // Empty with both requests: push only, no fall-through.
        repeat (7) cycle(1'b0, 1'b1);
        check("empty_again", empty_o, 1);
        cycle(1'b1, 1'b1);
        check("empty_both_count", count_o, 1);

        // Random traffic with wrap-around; compared every cycle by the model.
        for (int i = 0; i < 100; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Bring occupancy to 5, then reset asynchronously between edges.
        for (int i = 0; i < 20 && (m_wr - m_rd) < 5; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 20 && (m_wr - m_rd) > 5; i++) cycle(1'b0, 1'b1);
        push_i = 1'b0;
        pop_i  = 1'b0;
        check("pre_reset_count", count_o, 5);
        #2;
        arst_ni = 1'b0;
        m_wr    = 0;
        m_rd    = 0;
        prev_wg = '0;
        prev_rg = '0;
        #1 check_reset_values("mid_reset");
        @(posedge clk_i);
        #1 arst_ni = 1'b1;
        cycle(1'b1, 1'b0);
        check("post_reset_count", count_o, 1);
        cycle(1'b0, 1'b0);

        @(negedge clk_i);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
